// File: rtl/shift_seq_unit.sv
// Multi-cycle shift sequencer: parallel load, then shift one position per cycle
// in logical/arithmetic/rotate/serial-fill mode. Rotate is compiled in only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq_unit #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          start,
  input  logic [W-1:0]  data_in,
  input  logic [CW-1:0] amt,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          sin,
  output logic [W-1:0]  data_out,
  output logic          b_out,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    M_LOGIC  = 2'b00,
    M_ARITH  = 2'b01,
    M_ROT    = 2'b10,
    M_SERIAL = 2'b11
  } mode_e;

  state_e        state, state_nxt;
  mode_e         mode_q, mode_nxt;
  logic          dir_q, dir_nxt;
  logic          sin_q, sin_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  data_nxt;
  logic          b_nxt, busy_nxt, done_nxt;
  logic          fill;
  logic [CW-1:0] amt_sat;

  // Amounts beyond the register width flush it completely, so clamp at W.
  assign amt_sat = (amt > CW'(W)) ? CW'(W) : amt;

  // Bit entering the vacated end of the register on each shift step.
  always_comb begin
    fill = 1'b0;
    case (mode_q)
      M_ARITH:  fill = dir_q ? 1'b0 : data_out[W-1];
      M_SERIAL: fill = sin_q;
`ifdef SHIFT_SEQ_ROTATE_EN
      M_ROT:    fill = dir_q ? data_out[W-1] : data_out[0];
`endif
      default:  fill = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    b_nxt     = b_out;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    mode_nxt  = mode_q;
    sin_nxt   = sin_q;
    case (state)
      IDLE: begin
        if (start) begin
          dir_nxt   = dir;
          mode_nxt  = mode_e'(mode);
          sin_nxt   = sin;
          cnt_nxt   = amt_sat;
          state_nxt = (amt_sat != '0) ? SHIFT : DONE;
        end else if (ld) begin
          data_nxt = data_in;
          b_nxt    = 1'b0;
        end
      end
      SHIFT: begin
        if (dir_q) begin
          data_nxt = {data_out[W-2:0], fill};
          b_nxt    = data_out[W-1];
        end else begin
          data_nxt = {fill, data_out[W-1:1]};
          b_nxt    = data_out[0];
        end
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SHIFT);
    done_nxt = (state_nxt == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_out <= '0;
      b_out    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      dir_q    <= 1'b0;
      mode_q   <= M_LOGIC;
      sin_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_out <= data_nxt;
      b_out    <= b_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      cnt      <= cnt_nxt;
      dir_q    <= dir_nxt;
      mode_q   <= mode_nxt;
      sin_q    <= sin_nxt;
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit (W=8): vector table driven through a
// scoreboard queue, plus hand sequences for reset, start/ld priority and abort.
module tb_shift_seq_unit;

  logic       clk = 1'b0;
  logic       rst, ld, start, dir, sin;
  logic [7:0] data_in;
  logic [3:0] amt;
  logic [1:0] mode;
  logic [7:0] data_out;
  logic       b_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] d;
    logic [3:0] amt;
    logic       dir;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] exp_d;
    logic       exp_b;
    int         n;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       b;
    int         n;
  } exp_t;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam logic [7:0] ROTL_EXP = 8'h5A;
  localparam logic [7:0] ROTR_EXP = 8'h30;
`else
  localparam logic [7:0] ROTL_EXP = 8'h50;
  localparam logic [7:0] ROTR_EXP = 8'h10;
`endif

  vec_t vecs[12];
  exp_t sb[$];

  shift_seq_unit #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .start    (start),
    .data_in  (data_in),
    .amt      (amt),
    .dir      (dir),
    .mode     (mode),
    .sin      (sin),
    .data_out (data_out),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   busy_cnt;
    bit   seen;
    ld = 1'b1; data_in = v.d;
    @(negedge clk);
    ld = 1'b0;
    start = 1'b1; amt = v.amt; dir = v.dir; mode = v.mode; sin = v.sin;
    sb.push_back('{d: v.exp_d, b: v.exp_b, n: v.n});
    @(negedge clk);
    // Operands are don't-care once start has been sampled.
    start = 1'b0;
    amt = 4'($urandom); dir = 1'($urandom); mode = 2'($urandom); sin = 1'($urandom);
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k <= 20 && !seen; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        e = sb.pop_front();
        check($sformatf("v%0d data_out", idx), 32'(data_out), 32'(e.d));
        check($sformatf("v%0d b_out", idx), 32'(b_out), 32'(e.b));
        check($sformatf("v%0d busy cycles", idx), 32'(busy_cnt), 32'(e.n));
        check($sformatf("v%0d done latency", idx), 32'(k), 32'(e.n));
        check($sformatf("v%0d busy with done", idx), 32'(busy), 32'd0);
      end
      @(negedge clk);
    end
    if (seen) begin
      check($sformatf("v%0d done one cycle", idx), 32'(done), 32'd0);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d done timeout: got no done, expected done after %0d cycles", idx, v.n);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    bit saw_done;
    //            d      amt   dir   mode   sin   exp_d     exp_b n
    vecs[0]  = '{8'hA5, 4'd3,  1'b0, 2'b00, 1'b0, 8'h14,    1'b1, 3};
    vecs[1]  = '{8'h96, 4'd2,  1'b0, 2'b01, 1'b0, 8'hE5,    1'b1, 2};
    vecs[2]  = '{8'hA5, 4'd4,  1'b1, 2'b10, 1'b0, ROTL_EXP, 1'b0, 4};
    vecs[3]  = '{8'hFF, 4'd12, 1'b0, 2'b00, 1'b0, 8'h00,    1'b1, 8};
    vecs[4]  = '{8'h3C, 4'd0,  1'b1, 2'b00, 1'b1, 8'h3C,    1'b0, 0};
    vecs[5]  = '{8'h81, 4'd1,  1'b1, 2'b01, 1'b0, 8'h02,    1'b1, 1};
    vecs[6]  = '{8'h0F, 4'd3,  1'b1, 2'b11, 1'b1, 8'h7F,    1'b0, 3};
    vecs[7]  = '{8'h70, 4'd2,  1'b0, 2'b11, 1'b1, 8'hDC,    1'b0, 2};
    vecs[8]  = '{8'h80, 4'd8,  1'b0, 2'b01, 1'b0, 8'hFF,    1'b1, 8};
    vecs[9]  = '{8'hC3, 4'd5,  1'b0, 2'b01, 1'b0, 8'hFE,    1'b0, 5};
    vecs[10] = '{8'h81, 4'd3,  1'b0, 2'b10, 1'b0, ROTR_EXP, 1'b0, 3};
    vecs[11] = '{8'h01, 4'd15, 1'b1, 2'b00, 1'b0, 8'h00,    1'b1, 8};

    rst = 1'b1; ld = 1'b0; start = 1'b0; data_in = 8'h00;
    amt = 4'd0; dir = 1'b0; mode = 2'b00; sin = 1'b0;

    // Reset held two cycles, with start requested to show reset priority.
    @(negedge clk);
    start = 1'b1; amt = 4'd5;
    @(negedge clk);
    check("reset data_out", 32'(data_out), 32'h00);
    check("reset b_out", 32'(b_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // start wins over ld in the same cycle: with amt=0 the data must stay as loaded.
    ld = 1'b1; data_in = 8'hF0;
    @(negedge clk);
    data_in = 8'h0F; start = 1'b1; amt = 4'd0; dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    check("prio done", 32'(done), 32'd1);
    check("prio data_out", 32'(data_out), 32'hF0);
    @(negedge clk);

    // Abort: ld during SHIFT is ignored, reset in the 3rd busy cycle kills the op.
    ld = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    ld = 1'b0; start = 1'b1; amt = 4'd8; dir = 1'b0; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("abort busy1", 32'(busy), 32'd1);
    ld = 1'b1; data_in = 8'h11;
    @(negedge clk);
    ld = 1'b0;
    check("abort ld ignored", 32'(data_out), 32'h7F);
    @(negedge clk);
    check("abort busy3", 32'(busy), 32'd1);
    check("abort data before rst", 32'(data_out), 32'h3F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort data_out", 32'(data_out), 32'h00);
    check("abort b_out", 32'(b_out), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort no done later", 32'(saw_done), 32'd0);

    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 SHALL provide parameter W, default 8, meaning data register width in bits (W >= 2).
REQ-002 SHALL provide parameter CW, default ceil(log2(W))+1, meaning width of the shift-amount and counter fields.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port ld  input  1  parallel load request, active high.
REQ-006 SHALL have port start  input  1  multi-cycle shift request, active high.
REQ-007 SHALL have port data_in  input  W  parallel load data.
REQ-008 SHALL have port amt  input  CW  number of positions to shift.
REQ-009 SHALL have port dir  input  1  direction: 0 = right, 1 = left.
REQ-010 SHALL have port mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 serial-fill.
REQ-011 SHALL have port sin  input  1  fill bit for serial-fill mode.
REQ-012 SHALL have port data_out  output  W  current register contents.
REQ-013 SHALL have port b_out  output  1  last bit shifted out.
REQ-014 SHALL have port busy  output  1  high while in SHIFT state.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-017 In IDLE with start=1: latch dir, mode, sin and min(amt, W) into internal registers; next state SHIFT if the latched amount > 0, else DONE.
REQ-018 In IDLE with start=0 and ld=1: data_out <= data_in, b_out <= 0; state stays IDLE. start has priority over ld.
REQ-019 In SHIFT, each cycle SHALL shift data_out one position, decrement the counter, and move to DONE when the counter goes 1 -> 0.
REQ-020 Right shift fill bit: logical 0; arithmetic data_out[W-1]; rotate data_out[0]; serial-fill latched sin.
REQ-021 Left shift fill bit: logical 0; arithmetic 0; rotate data_out[W-1]; serial-fill latched sin.
REQ-022 Each shift SHALL load b_out with the bit leaving the register: data_out[0] for right shifts, data_out[W-1] for left shifts.
REQ-023 busy SHALL be 1 exactly in SHIFT. done SHALL be 1 exactly in DONE, for one cycle. DONE SHALL always return to IDLE.
REQ-024 Latency: start sampled at edge t gives busy for N = min(amt, W) cycles and done at cycle t+N+1; for amt=0, done is asserted at t+1 and data is unchanged.
REQ-025 ld and start SHALL be ignored in SHIFT and DONE. Inputs dir, mode, sin, amt SHALL be don't-care after the start cycle.
REQ-026 amt > W SHALL saturate to W, so a logical or arithmetic shift fully flushes the register.

Reset
REQ-027 When rst=1 at a clock edge: data_out=0, b_out=0, busy=0, done=0, counter=0, state=IDLE. rst has priority over all inputs.
REQ-028 Reset during SHIFT SHALL abort the operation, with no done pulse.

Configuration
REQ-029 Macro SHIFT_SEQ_ROTATE_EN, when defined, compiles in rotate mode as specified in REQ-020/021.
REQ-030 Without SHIFT_SEQ_ROTATE_EN, mode 10 SHALL behave exactly as logical mode 00, and no rotate feedback logic is present.

Verification (W=8)
REQ-031 Reset: hold rst=1 for 2 cycles -> data_out=0x00, b_out=0, busy=0, done=0.
REQ-032 Load then logical right: ld with 0xA5, then start with amt=3, dir=0, mode=00 -> busy for 3 cycles, then done; data_out=0x14, b_out=1.
REQ-033 Arithmetic right: load 0x96, start with amt=2, dir=0, mode=01 -> data_out=0xE5, b_out=1, done at start+3.
REQ-034 Rotate left: load 0xA5, start with amt=4, dir=1, mode=10 -> data_out=0x5A, b_out=0 with the macro defined; data_out=0x50 without it.
REQ-035 Edge amounts: amt=0 -> done at the next cycle, data unchanged, busy never asserted; amt=12 with logical right on 0xFF -> 8 busy cycles, data_out=0x00, b_out=1.
REQ-036 Abort and ignore: start with amt=8 on 0xFF, assert ld with 0x11 during SHIFT (ignored), then rst in the 3rd busy cycle -> all outputs 0, state IDLE, no done pulse.
